// File: rtl/mac_operand_loader.sv
// Stream-to-matrix operand loader for the MAC: collects A, B and optionally C from a
// 32-bit word stream, then presents the complete operand set under a valid/ready handshake.
module mac_operand_loader #(
    parameter int unsigned M = 2,
    parameter int unsigned N = 2,
    parameter int unsigned K = 2,
    parameter int unsigned P = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [31:0]         s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic                s_last_i,
    input  logic                zero_c_i,
    output logic [M*K*P-1:0]    A_o,
    output logic [K*N*P-1:0]    B_o,
    output logic [M*N*32-1:0]   C_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                err_o,
    output logic                busy_o
);

    localparam int unsigned SizeA   = M * K;
    localparam int unsigned SizeB   = K * N;
    localparam int unsigned SizeC   = M * N;
    localparam int unsigned MaxAB   = (SizeA > SizeB) ? SizeA : SizeB;
    localparam int unsigned MaxSize = (MaxAB > SizeC) ? MaxAB : SizeC;
    localparam int unsigned IdxW    = (MaxSize > 1) ? $clog2(MaxSize) : 1;

    localparam logic [IdxW-1:0] LastA = IdxW'(SizeA - 1);
    localparam logic [IdxW-1:0] LastB = IdxW'(SizeB - 1);
    localparam logic [IdxW-1:0] LastC = IdxW'(SizeC - 1);

    typedef enum logic [1:0] {StLoadA, StLoadB, StLoadC, StPresent} state_e;

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       zflag_q;
    logic                       err_q;
    logic [SizeA-1:0][P-1:0]    a_q;
    logic [SizeB-1:0][P-1:0]    b_q;
    logic [SizeC-1:0][31:0]     c_q;

    logic accept;
    logic phase_done;
    logic final_beat;
    logic clear_c;

    assign s_ready_o = rst_ni && (state_q != StPresent);
    assign accept    = s_valid_i && s_ready_o;
    assign valid_o   = (state_q == StPresent);
    assign busy_o    = (state_q != StLoadA) || (idx_q != '0);
    assign err_o     = err_q;
    assign A_o       = a_q;
    assign B_o       = b_q;
    assign C_o       = c_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_done = 1'b0;
        final_beat = 1'b0;
        clear_c    = 1'b0;
        unique case (state_q)
            StLoadA: begin
                phase_done = (idx_q == LastA);
                if (accept && phase_done) state_d = StLoadB;
            end
            StLoadB: begin
                phase_done = (idx_q == LastB);
                final_beat = phase_done && zflag_q;
                // Zero-C frames end here: C is cleared on the same edge that enters PRESENT.
                clear_c    = accept && final_beat;
                if (accept && phase_done) state_d = zflag_q ? StPresent : StLoadC;
            end
            StLoadC: begin
                phase_done = (idx_q == LastC);
                final_beat = phase_done;
                if (accept && phase_done) state_d = StPresent;
            end
            StPresent: begin
                if (ready_i) begin
                    state_d = StLoadA;
                    idx_d   = '0;
                end
            end
            default: state_d = StLoadA;
        endcase
        if (accept) idx_d = phase_done ? '0 : idx_q + IdxW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StLoadA;
            idx_q   <= '0;
            zflag_q <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept && (state_q == StLoadA) && (idx_q == '0)) zflag_q <= zero_c_i;
            if (accept && (s_last_i != final_beat)) err_q <= 1'b1;
            for (int i = 0; i < SizeA; i++) begin
                if (accept && (state_q == StLoadA) && (idx_q == IdxW'(i))) begin
                    a_q[i] <= s_data_i[P-1:0];
                end
            end
            for (int i = 0; i < SizeB; i++) begin
                if (accept && (state_q == StLoadB) && (idx_q == IdxW'(i))) begin
                    b_q[i] <= s_data_i[P-1:0];
                end
            end
            for (int i = 0; i < SizeC; i++) begin
                if (accept && (state_q == StLoadC) && (idx_q == IdxW'(i))) begin
                    c_q[i] <= s_data_i;
                end
            end
            if (clear_c) c_q <= '0;
        end
    end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Bench for mac_operand_loader: directed frame table, reset/hold corner cases and random
// frames checked against a frame-level reference model.
module tb_mac_operand_loader;

    localparam int unsigned M = 2;
    localparam int unsigned N = 2;
    localparam int unsigned K = 2;
    localparam int unsigned P = 8;
    localparam int NA = M * K;
    localparam int NB = K * N;
    localparam int NC = M * N;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic [31:0]         s_data;
    logic                s_valid;
    logic                s_ready;
    logic                s_last;
    logic                zero_c;
    logic [M*K*P-1:0]    a_out;
    logic [K*N*P-1:0]    b_out;
    logic [M*N*32-1:0]   c_out;
    logic                valid;
    logic                ready;
    logic                err;
    logic                busy;

    always #5 clk = ~clk;

    mac_operand_loader #(.M(M), .N(N), .K(K), .P(P)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_last_i  (s_last),
        .zero_c_i  (zero_c),
        .A_o       (a_out),
        .B_o       (b_out),
        .C_o       (c_out),
        .valid_o   (valid),
        .ready_i   (ready),
        .err_o     (err),
        .busy_o    (busy)
    );

    int vectors = 0;
    int miscompares = 0;
    bit err_model = 1'b0;

    typedef struct {
        logic [31:0]  w [12];
        bit           zc;
        logic [11:0]  lastm;
        bit           gaps;
        int           hold;
        logic [31:0]  exp_a;
        logic [31:0]  exp_b;
        logic [127:0] exp_c;
        bit           exp_err;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic beat(input logic [31:0] d, input bit last, input bit zc, input bit gaps);
        int guard;
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            repeat ($urandom_range(1, 3)) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = $urandom_range(0, 1);
                @(negedge clk);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        zero_c  = zc;
        guard   = 0;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("beat_timeout", 128'd0, 128'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] w [12], input bit zc, input logic [11:0] lastm,
                             input bit gaps, input int hold, input logic [31:0] exp_a,
                             input logic [31:0] exp_b, input logic [127:0] exp_c);
        int  n;
        bit  fin;
        n = zc ? NA + NB : NA + NB + NC;
        for (int i = 0; i < n; i++) begin
            fin = (i == n - 1);
            beat(w[i], lastm[i], (i == 0) ? zc : 1'($urandom_range(0, 1)), gaps);
            if (lastm[i] != fin) err_model = 1'b1;
            check("err_o", {127'd0, err}, {127'd0, err_model});
            if (!fin) check("busy_mid", {127'd0, busy}, 128'd1);
        end
        check("valid_rise", {127'd0, valid}, 128'd1);
        check("ready_low_present", {127'd0, s_ready}, 128'd0);
        check("A_o", {96'd0, a_out}, {96'd0, exp_a});
        check("B_o", {96'd0, b_out}, {96'd0, exp_b});
        check("C_o", c_out, exp_c);
        for (int h = 0; h < hold; h++) begin
            s_valid = 1'b1;
            s_data  = 32'hFF;
            @(negedge clk);
            check("valid_hold", {127'd0, valid}, 128'd1);
            check("hold_outputs", {a_out, b_out, c_out[63:0]}, {exp_a, exp_b, exp_c[63:0]});
        end
        s_valid = 1'b0;
        ready   = 1'b1;
        @(negedge clk);
        ready   = 1'b0;
        check("valid_fall", {127'd0, valid}, 128'd0);
        check("ready_after_xfer", {127'd0, s_ready}, 128'd1);
        check("busy_after_xfer", {127'd0, busy}, 128'd0);
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        s_valid = 1'b0;
        #1;
        check("ready_in_reset", {127'd0, s_ready}, 128'd0);
        @(negedge clk);
        rst_ni    = 1'b1;
        err_model = 1'b0;
        check("rst_valid", {127'd0, valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_err", {127'd0, err}, 128'd0);
        check("rst_outputs", {a_out, b_out, c_out[63:0]}, 128'd0);
        check("rst_c_hi", {64'd0, c_out[127:64]}, 128'd0);
        #1;
        check("rst_ready", {127'd0, s_ready}, 128'd1);
    endtask

    initial begin
        logic [31:0]  w [12];
        logic [31:0]  ea, eb;
        logic [127:0] ec;
        logic [11:0]  lm;
        bit           zc;
        int           n;

        tbl[0].w      = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                          32'd10, 32'd20, 32'd30, 32'd40};
        tbl[0].zc     = 1'b0;
        tbl[0].lastm  = 12'h800;
        tbl[0].gaps   = 1'b0;
        tbl[0].hold   = 0;
        tbl[0].exp_a  = 32'h04030201;
        tbl[0].exp_b  = 32'h08070605;
        tbl[0].exp_c  = {32'd40, 32'd30, 32'd20, 32'd10};
        tbl[0].exp_err = 1'b0;

        tbl[1]        = tbl[0];
        tbl[1].zc     = 1'b1;
        tbl[1].lastm  = 12'h080;
        tbl[1].hold   = 10;
        tbl[1].exp_c  = '0;

        tbl[2]        = tbl[0];
        tbl[2].w[0]   = 32'h0000_01FF;
        tbl[2].gaps   = 1'b1;
        tbl[2].exp_a  = 32'h040302FF;

        tbl[3]        = tbl[0];
        tbl[3].lastm  = 12'h810;
        tbl[3].exp_err = 1'b1;

        tbl[4]        = tbl[0];
        tbl[4].exp_err = 1'b1;

        rst_ni  = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        zero_c  = 1'b0;
        ready   = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        foreach (tbl[i]) begin
            run_frame(tbl[i].w, tbl[i].zc, tbl[i].lastm, tbl[i].gaps, tbl[i].hold,
                      tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_c);
            check("err_final", {127'd0, err}, {127'd0, tbl[i].exp_err});
        end

        // Partial frame, then reset discards it.
        for (int i = 0; i < 6; i++) beat(tbl[0].w[i], 1'b0, 1'b0, 1'b0);
        check("busy_partial", {127'd0, busy}, 128'd1);
        do_reset();
        run_frame(tbl[0].w, tbl[0].zc, tbl[0].lastm, 1'b0, 0,
                  tbl[0].exp_a, tbl[0].exp_b, tbl[0].exp_c);
        check("err_after_reset", {127'd0, err}, 128'd0);

        // Random frames against the frame-level model.
        for (int f = 0; f < 20; f++) begin
            zc = 1'($urandom_range(0, 1));
            n  = zc ? NA + NB : NA + NB + NC;
            foreach (w[i]) w[i] = $urandom;
            lm = 12'd1 << (n - 1);
            ea = '0;
            eb = '0;
            ec = '0;
            for (int i = 0; i < NA; i++) ea[i*P +: P] = w[i][P-1:0];
            for (int i = 0; i < NB; i++) eb[i*P +: P] = w[NA+i][P-1:0];
            if (!zc) for (int i = 0; i < NC; i++) ec[i*32 +: 32] = w[NA+NB+i];
            run_frame(w, zc, lm, 1'b1, $urandom_range(0, 3), ea, eb, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_operand_loader.md
Name: mac_operand_loader

Overview:
- Initiator/transmitter side of the matrix MAC operand handshake (valid_in/ready_in).
- Deserialises a 32-bit word stream into the A[M][K], B[K][N] and C[M][N] operand matrices.
- Presents the complete operand set to the MAC with a valid/ready handshake.
- Sits between the system-side operand stream (DMA/streamer) and matrix_multiplication_accumulation.

Parameters:
M, 2, rows of A, C and D
N, 2, columns of B, C and D
K, 2, columns of A and rows of B
P, 8, operand bit width of A and B elements (2..16)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  synchronous active-low reset
s_data_i  input  32  stream word, one matrix element per beat
s_valid_i  input  1  stream word valid
s_ready_o  output  1  loader accepts stream word
s_last_i  input  1  sender marks final beat of frame
zero_c_i  input  1  sampled on first beat: C loaded as zeros, C phase skipped
A_o  output  M x K x P signed  operand A, row-major
B_o  output  K x N x P signed  operand B, row-major
C_o  output  M x N x 32 signed  accumulator input C
valid_o  output  1  operands complete and stable (drives MAC valid_in)
ready_i  input  1  MAC accepts operands (from MAC ready_in)
err_o  output  1  sticky framing error
busy_o  output  1  frame partially loaded (state not LOAD_A, or LOAD_A with index > 0)

Behaviour:
- A beat is accepted when s_valid_i and s_ready_o are both high. An operand transfer completes when valid_o and ready_i are both high.
- Frame order, all row-major:
  - A: M*K beats, element = s_data_i[P-1:0].
  - B: K*N beats, element = s_data_i[P-1:0].
  - C: M*N beats, element = s_data_i[31:0], unless skipped.
- Bits s_data_i[31:P] are ignored for A and B.
- States are LOAD_A, LOAD_B, LOAD_C and PRESENT. One element index counter runs from 0 up to phase size minus 1. It clears on every phase change.
- LOAD_A: the element at the current index is written.
  - Index 0 beat also latches zero_c_i into zflag.
  - Last index goes to LOAD_B.
- LOAD_B: last index goes to LOAD_C if zflag is 0. If zflag is 1, it clears all C registers to 0 in the same edge and goes to PRESENT.
- LOAD_C: last index goes to PRESENT.
- PRESENT:
  - valid_o = 1, s_ready_o = 0.
  - A_o, B_o and C_o are held constant.
  - A transfer goes to LOAD_A with index 0.
  - valid_o is held while ready_i stays low; there is no timeout.
- s_ready_o = 1 in every LOAD_x state; it is combinational from state.
- Latency: valid_o rises the cycle after the final accepted beat. s_ready_o rises the cycle after the operand transfer.
- Minimum period per operation is M*K + K*N + M*N + 1 cycles, or M*K + K*N + 1 with zflag set. There is a single operand buffer and no overlap.
- Framing check:
  - s_last_i must be 1 exactly on the final beat of the frame. That is the last C beat, or the last B beat when zflag is set.
  - s_last_i = 1 on any other accepted beat sets err_o. The frame continues normally (no resync).
  - s_last_i = 0 on the final beat also sets err_o, and the state machine still goes to PRESENT.
- err_o clears only on reset.
- Reset values (applied the cycle rst_ni is sampled low):
  - state LOAD_A, index 0, zflag 0.
  - All A/B/C registers 0.
  - valid_o 0, err_o 0, busy_o 0.
- s_ready_o is forced 0 while rst_ni is low.
- Reset mid-frame or in PRESENT discards all loaded data. No transfer is signalled.
- s_valid_i low mid-phase: the index holds and no register changes.
- Edge case M*K = 1, or any phase size of 1: that phase completes on its single beat.

Test Plan:
- M=N=K=2, P=8. Stream 12 beats: A = 1,2,3,4; B = 5,6,7,8; C = 10,20,30,40; s_last on beat 12; ready_i = 1. Required: valid_o high on the cycle after beat 12 with A_o = [[1,2],[3,4]], B_o = [[5,6],[7,8]], C_o = [[10,20],[30,40]]; s_ready_o low that cycle, then high the next cycle; err_o = 0.
- Same A/B with zero_c_i = 1 on beat 1 and s_last on beat 8. Required: valid_o after beat 8, C_o all zeros; the next frame is accepted immediately after the transfer.
- Hold ready_i = 0 for 10 cycles in PRESENT while s_valid_i = 1 with data 0xFF. Required: valid_o held, outputs unchanged, no beat accepted. ready_i = 1 gives exactly one transfer.
- A beat s_data_i = 0x0000_01FF with P = 8. Required: element = -1 (0xFF). Then randomly deassert s_valid_i mid-phase; required: final matrices identical to the gap-free case.
- s_last_i = 1 on beat 5. Required: err_o = 1 from the next cycle onward; the frame still completes after 12 beats; err_o stays 1 until reset.
- Assert rst_ni = 0 for 1 cycle after beat 6. Required: valid_o = 0, busy_o = 0, all outputs 0. A fresh 12-beat frame then loads correctly.
